mult_seq_skip_param: RTL and testbench

//  Parametrised sequential multiplier: datapath plus control FSM. Computes unsigned
//  a*b by accumulating one A_CHUNK x B_CHUNK partial product per cycle.

---
 rtl/mult_seq_skip_param.sv | 140 ++++++++++++++
 tb/tb_mult_seq_skip_param.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_skip_param.sv
// Sequential unsigned multiplier: one A_CHUNK x B_CHUNK partial product per RUN cycle,
// with all-zero upper chunks of either operand skipped and a registered done pulse.
module mult_seq_skip_param #(
    parameter int A_W     = 32,
    parameter int B_W     = 32,
    parameter int A_CHUNK = 8,
    parameter int B_CHUNK = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    output logic                 busy,
    output logic                 done,
    output logic [A_W+B_W-1:0]   product
);

    localparam int NA  = A_W / A_CHUNK;
    localparam int NB  = B_W / B_CHUNK;
    localparam int P_W = A_W + B_W;
    localparam int NAW = $clog2(NA + 1);
    localparam int NBW = $clog2(NB + 1);
    localparam int SW  = $clog2(P_W);
    localparam int PPW = A_CHUNK + B_CHUNK;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [A_W-1:0]   a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [NAW-1:0]   i_q, i_d, na_q, na_d;
    logic [NBW-1:0]   j_q, j_d, nb_q, nb_d;
    logic [P_W-1:0]   product_q, product_d;
    logic             done_q, done_d;

    logic [A_CHUNK-1:0] a_slice;
    logic [B_CHUNK-1:0] b_slice;
    logic [PPW-1:0]     pp;
    logic [SW-1:0]      sh;
    logic [P_W-1:0]     pp_sh;

    // Number of A chunks up to and including the highest nonzero one (at least 1).
    function automatic logic [NAW-1:0] eff_a(input logic [A_W-1:0] v);
        logic [NAW-1:0] n;
        n = NAW'(1);
        for (int k = 0; k < NA; k++) begin
            if (v[k*A_CHUNK +: A_CHUNK] != '0) n = NAW'(k + 1);
        end
        return n;
    endfunction

    function automatic logic [NBW-1:0] eff_b(input logic [B_W-1:0] v);
        logic [NBW-1:0] n;
        n = NBW'(1);
        for (int k = 0; k < NB; k++) begin
            if (v[k*B_CHUNK +: B_CHUNK] != '0) n = NBW'(k + 1);
        end
        return n;
    endfunction

    assign a_slice = a_q[i_q*A_CHUNK +: A_CHUNK];
    assign b_slice = b_q[j_q*B_CHUNK +: B_CHUNK];
    assign pp      = a_slice * b_slice;
    assign sh      = SW'(i_q * A_CHUNK + j_q * B_CHUNK);
    assign pp_sh   = P_W'(pp) << sh;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        i_d       = i_q;
        j_d       = j_q;
        na_d      = na_q;
        nb_d      = nb_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    a_d       = a;
                    b_d       = b;
                    product_d = '0;
                    i_d       = '0;
                    j_d       = '0;
                    na_d      = eff_a(a);
                    nb_d      = eff_b(b);
                end
            end
            RUN: begin
                product_d = product_q + pp_sh;
                // i is the inner index; the final pair returns to IDLE and pulses done
                if (i_q == na_q - NAW'(1)) begin
                    i_d = '0;
                    if (j_q == nb_q - NBW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        j_d = j_q + NBW'(1);
                    end
                end else begin
                    i_d = i_q + NAW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            na_q      <= NAW'(1);
            nb_q      <= NBW'(1);
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            na_q      <= na_d;
            nb_q      <= nb_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    // Captured operands are pure data and need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mult_seq_skip_param.sv
// Bench for mult_seq_skip_param: default 32x32/8/16 instance and a 16x16/4/8 instance,
// checked against plain a*b and a bit-length based busy-cycle model.
module tb_mult_seq_skip_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic [31:0] a0, b0;
    logic [15:0] a1, b1;
    logic        busy0, done0, busy1, done1;
    logic [63:0] product0;
    logic [31:0] product1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mult_seq_skip_param dut0 (
        .clk(clk), .reset(reset), .start(start0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .product(product0)
    );

    mult_seq_skip_param #(.A_W(16), .B_W(16), .A_CHUNK(4), .B_CHUNK(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .product(product1)
    );

    function automatic int bitlen(input longint unsigned v);
        int n = 0;
        while (v != 0) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    // Chunks needed to hold v, minimum one.
    function automatic int eff(input longint unsigned v, input int chunk);
        return (v == 0) ? 1 : (bitlen(v) + chunk - 1) / chunk;
    endfunction

    task automatic op0(input logic [31:0] a, input logic [31:0] b, output int cnt,
                       output logic [63:0] prod, output logic dn, output logic dn_after);
        @(negedge clk);
        a0 = a; b0 = b; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cnt = 0;
        while (busy0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        dn = done0;
        prod = product0;
        @(negedge clk);
        dn_after = done0;
    endtask

    task automatic op1(input logic [15:0] a, input logic [15:0] b, output int cnt,
                       output logic [31:0] prod, output logic dn, output logic dn_after);
        @(negedge clk);
        a1 = a; b1 = b; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cnt = 0;
        while (busy1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        dn = done1;
        prod = product1;
        @(negedge clk);
        dn_after = done1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #1;
        vectors++;
        if ({busy0, done0, busy1, done1} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000", {busy0, done0, busy1, done1});
        end
        vectors++;
        if (product0 !== 64'd0 || product1 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_product: got %h/%h expected 0", product0, product1);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_full();
        int cnt; logic [63:0] p; logic dn, dna;
        op0(32'hFFFF_FFFF, 32'hFFFF_FFFF, cnt, p, dn, dna);
        vectors++;
        if (p !== 64'hFFFF_FFFE_0000_0001) begin
            miscompares++;
            $display("FAIL full_product: got %h expected %h", p, 64'hFFFF_FFFE_0000_0001);
        end
        vectors++;
        if (cnt !== 8) begin
            miscompares++;
            $display("FAIL full_busy: got %0d expected 8", cnt);
        end
        vectors++;
        if (dn !== 1'b1 || dna !== 1'b0) begin
            miscompares++;
            $display("FAIL full_done_pulse: got %b%b expected 10", dn, dna);
        end
        vectors++;
        if (product0 !== 64'hFFFF_FFFE_0000_0001) begin
            miscompares++;
            $display("FAIL full_hold: got %h expected %h", product0, 64'hFFFF_FFFE_0000_0001);
        end
    endtask

    task automatic test_skip();
        int cnt; logic [63:0] p; logic dn, dna;
        op0(32'h00FF_FFFF, 32'h0000_FFFF, cnt, p, dn, dna);
        vectors++;
        if (p !== 64'h0000_00FF_FEFF_0001 || cnt !== 3) begin
            miscompares++;
            $display("FAIL skip_upper: got %h/%0d expected %h/3", p, cnt, 64'h0000_00FF_FEFF_0001);
        end
        op0(32'd5, 32'd7, cnt, p, dn, dna);
        vectors++;
        if (p !== 64'd35 || cnt !== 1 || dn !== 1'b1) begin
            miscompares++;
            $display("FAIL small_ops: got %0d/%0d/%b expected 35/1/1", p, cnt, dn);
        end
        op0(32'h1234_5678, 32'd0, cnt, p, dn, dna);
        vectors++;
        if (p !== 64'd0 || cnt !== 4) begin
            miscompares++;
            $display("FAIL b_zero: got %h/%0d expected 0/4", p, cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int cnt; logic [63:0] p; logic dn, dna;
        @(negedge clk);
        a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || product0 !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_mid_run: got busy=%b done=%b prod=%h expected 0/0/0",
                     busy0, done0, product0);
        end
        @(negedge clk);
        reset = 1'b0;
        op0(32'd3, 32'd4, cnt, p, dn, dna);
        vectors++;
        if (p !== 64'd12 || cnt !== 1) begin
            miscompares++;
            $display("FAIL after_reset: got %0d/%0d expected 12/1", p, cnt);
        end
    endtask

    task automatic test_start_while_busy();
        int cnt;
        @(negedge clk);
        a0 = 32'h89AB_CDEF; b0 = 32'h0000_1234; start0 = 1'b1;
        @(negedge clk);
        a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF;
        cnt = 0;
        while (busy0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
            if (cnt == 2) start0 = 1'b0;
        end
        vectors++;
        if (product0 !== 64'h89AB_CDEF * 64'h1234 || cnt !== 4 || done0 !== 1'b1) begin
            miscompares++;
            $display("FAIL start_ignored: got %h/%0d/%b expected %h/4/1",
                     product0, cnt, done0, 64'h89AB_CDEF * 64'h1234);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        @(negedge clk);
        a0 = 32'h0001_0000; b0 = 32'd3; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cnt = 0;
        while (busy0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        vectors++;
        if (done0 !== 1'b1 || product0 !== 64'h3_0000 || cnt !== 3) begin
            miscompares++;
            $display("FAIL b2b_first: got %b/%h/%0d expected 1/30000/3", done0, product0, cnt);
        end
        a0 = 32'd7; b0 = 32'h0100_0000; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        vectors++;
        if (done0 !== 1'b0 || busy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_restart: got done=%b busy=%b expected 0/1", done0, busy0);
        end
        cnt = 0;
        while (busy0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        vectors++;
        if (product0 !== 64'h700_0000 || cnt !== 2 || done0 !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second: got %h/%0d/%b expected 7000000/2/1", product0, cnt, done0);
        end
    endtask

    task automatic test_small_params();
        int cnt; logic [31:0] p; logic dn, dna;
        op1(16'hFFFF, 16'hFFFF, cnt, p, dn, dna);
        vectors++;
        if (p !== 32'hFFFE_0001 || cnt !== 8 || dn !== 1'b1 || dna !== 1'b0) begin
            miscompares++;
            $display("FAIL small_param_full: got %h/%0d/%b%b expected fffe0001/8/10", p, cnt, dn, dna);
        end
    endtask

    task automatic test_random();
        int cnt, exp_cnt; logic dn, dna;
        logic [63:0] p0; logic [31:0] p1;
        logic [31:0] ra, rb; logic [15:0] sa, sb;
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom() >> $urandom_range(0, 32);
            rb = $urandom() >> $urandom_range(0, 32);
            op0(ra, rb, cnt, p0, dn, dna);
            exp_cnt = eff(ra, 8) * eff(rb, 16);
            vectors++;
            if (p0 !== 64'(longint'(ra) * longint'(rb))) begin
                miscompares++;
                $display("FAIL rand32_product: a=%h b=%h got %h expected %h",
                         ra, rb, p0, 64'(longint'(ra) * longint'(rb)));
            end
            vectors++;
            if (cnt !== exp_cnt || dn !== 1'b1 || dna !== 1'b0) begin
                miscompares++;
                $display("FAIL rand32_timing: a=%h b=%h got %0d/%b%b expected %0d/10",
                         ra, rb, cnt, dn, dna, exp_cnt);
            end
            sa = 16'($urandom() >> $urandom_range(16, 32));
            sb = 16'($urandom() >> $urandom_range(16, 32));
            op1(sa, sb, cnt, p1, dn, dna);
            exp_cnt = eff(sa, 4) * eff(sb, 8);
            vectors++;
            if (p1 !== 32'(int'(sa) * int'(sb))) begin
                miscompares++;
                $display("FAIL rand16_product: a=%h b=%h got %h expected %h",
                         sa, sb, p1, 32'(int'(sa) * int'(sb)));
            end
            vectors++;
            if (cnt !== exp_cnt || dn !== 1'b1 || dna !== 1'b0) begin
                miscompares++;
                $display("FAIL rand16_timing: a=%h b=%h got %0d/%b%b expected %0d/10",
                         sa, sb, cnt, dn, dna, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_skip();
        test_reset_mid_run();
        test_start_while_busy();
        test_back_to_back();
        test_small_params();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
